fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch sequencer. Accepts instruction words from the
//            ROM, resolves direct/conditional branches in the accept cycle,
//            and resolves register-based branches (CBZ/CBNZ/BR) one cycle
//            later, once the register file has returned the operand.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-high reset
//            INSTR     - instruction word at current PC
//            ROM_VALID - INSTR valid this cycle
//            STALL     - downstream hazard, blocks acceptance
//            FLAGS     - {N,Z,C,V} from the ALU
//            REG_VAL   - register data for REG_ADDR (cycle after REG_ADDR)
//            PS        - PC select: 00 hold, 01 inc, 10 load, 11 offset
//            PC_IN     - load/offset value (0 when PS is 00 or 01)
//            IR        - last accepted instruction
//            IR_VALID  - one-cycle pulse when IR is newly loaded
//            REG_ADDR  - register index for CBZ/CBNZ/BR
//            HALTED    - high while halted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR,
  input  logic        ROM_VALID,
  input  logic        STALL,
  input  logic [3:0]  FLAGS,
  input  logic [63:0] REG_VAL,
  output logic [1:0]  PS,
  output logic [63:0] PC_IN,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [4:0]  REG_ADDR,
  output logic        HALTED
);

  localparam logic [31:0] C_HLT_WORD = 32'hD440_0000;

  localparam logic [1:0] C_PS_HOLD = 2'b00;
  localparam logic [1:0] C_PS_INC  = 2'b01;
  localparam logic [1:0] C_PS_LOAD = 2'b10;
  localparam logic [1:0] C_PS_OFS  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_REGRD  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Kind of register-based branch waiting for its operand in ST_REGRD.
  typedef enum logic [1:0] {
    BT_NONE = 2'd0,
    BT_CBZ  = 2'd1,
    BT_CBNZ = 2'd2,
    BT_BR   = 2'd3
  } btype_t;

  state_t      state_q,    state_d;
  btype_t      btype_q,    btype_d;
  logic [31:0] ir_q,       ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [63:0] offset_q,   offset_d;

  logic        accept;
  logic        is_b, is_bcond, is_cbz, is_cbnz, is_br, is_hlt;
  logic [63:0] sext26, sext19;

  // Condition code evaluation; FLAGS = {N,Z,C,V}.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond[3:1])
      3'd0:    res = z;
      3'd1:    res = c;
      3'd2:    res = n;
      3'd3:    res = v;
      3'd4:    res = c & ~z;
      3'd5:    res = (n == v);
      3'd6:    res = ~z & (n == v);
      default: res = 1'b1;
    endcase
    // Odd codes invert the even partner, except 0xF which is also "always".
    if (cond[0] && (cond[3:1] != 3'd7)) begin
      res = ~res;
    end
    return res;
  endfunction

  assign is_b     = (INSTR[31:26] == 6'b000101);
  assign is_bcond = (INSTR[31:24] == 8'b01010100);
  assign is_cbz   = (INSTR[31:24] == 8'b10110100);
  assign is_cbnz  = (INSTR[31:24] == 8'b10110101);
  assign is_br    = (INSTR[31:21] == 11'b11010110000);
  assign is_hlt   = (INSTR == C_HLT_WORD);

  assign sext26 = {{38{INSTR[25]}}, INSTR[25:0]};
  assign sext19 = {{45{INSTR[23]}}, INSTR[23:5]};

  assign accept = (state_q == ST_FETCH) && ROM_VALID && !STALL;

  always_comb begin
    state_d    = state_q;
    btype_d    = btype_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    reg_addr_d = reg_addr_q;
    offset_d   = offset_q;
    PS         = C_PS_HOLD;
    PC_IN      = 64'd0;

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          ir_d       = INSTR;
          ir_valid_d = 1'b1;
          if (is_hlt) begin
            state_d = ST_HALTED;
          end else if (is_b) begin
            PS    = C_PS_OFS;
            PC_IN = sext26;
          end else if (is_bcond) begin
            if (cond_true(INSTR[3:0], FLAGS)) begin
              PS    = C_PS_OFS;
              PC_IN = sext19;
            end else begin
              PS = C_PS_INC;
            end
          end else if (is_cbz || is_cbnz) begin
            reg_addr_d = INSTR[4:0];
            btype_d    = is_cbz ? BT_CBZ : BT_CBNZ;
            offset_d   = sext19;
            state_d    = ST_REGRD;
          end else if (is_br) begin
            reg_addr_d = INSTR[9:5];
            btype_d    = BT_BR;
            offset_d   = 64'd0;
            state_d    = ST_REGRD;
          end else begin
            PS = C_PS_INC;
          end
        end
      end

      ST_REGRD: begin
        // Single-cycle resolution; ROM_VALID/STALL are deliberately ignored.
        case (btype_q)
          BT_CBZ: begin
            if (REG_VAL == 64'd0) begin
              PS    = C_PS_OFS;
              PC_IN = offset_q;
            end else begin
              PS = C_PS_INC;
            end
          end
          BT_CBNZ: begin
            if (REG_VAL != 64'd0) begin
              PS    = C_PS_OFS;
              PC_IN = offset_q;
            end else begin
              PS = C_PS_INC;
            end
          end
          BT_BR: begin
            PS    = C_PS_LOAD;
            PC_IN = REG_VAL;
          end
          default: PS = C_PS_INC;
        endcase
        state_d = ST_FETCH;
      end

      default: begin
        // Halted: hold PC until reset.
        state_d = ST_HALTED;
      end
    endcase

    // Reset must silence the PC controls immediately, not just at the edge.
    if (reset) begin
      PS    = C_PS_HOLD;
      PC_IN = 64'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      btype_q    <= BT_NONE;
      ir_q       <= 32'd0;
      ir_valid_q <= 1'b0;
      reg_addr_q <= 5'd0;
      offset_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      btype_q    <= btype_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      reg_addr_q <= reg_addr_d;
      offset_q   <= offset_d;
    end
  end

  assign IR       = ir_q;
  assign IR_VALID = ir_valid_q;
  assign REG_ADDR = reg_addr_q;
  assign HALTED   = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. PC controls are checked
//            mid-cycle against hand-derived values; accepted instructions are
//            queued and matched against IR whenever IR_VALID pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] C_ADD  = 32'h8B02_0020;
  localparam logic [31:0] C_BM3  = 32'h17FF_FFFD;
  localparam logic [31:0] C_BEQ4 = 32'h5400_0080;
  localparam logic [31:0] C_BNE4 = 32'h5400_0081;
  localparam logic [31:0] C_BGT  = 32'h5400_004C; // imm19=2, GT
  localparam logic [31:0] C_BLTM = 32'h54FF_FFEB; // imm19=-1, LT
  localparam logic [31:0] C_CBZ  = 32'hB400_0047; // Rt=7, imm19=2
  localparam logic [31:0] C_CBNZ = 32'hB500_0047;
  localparam logic [31:0] C_BR30 = 32'hD61F_03C0;
  localparam logic [31:0] C_HLT  = 32'hD440_0000;

  logic        clk;
  logic        reset;
  logic [31:0] INSTR;
  logic        ROM_VALID;
  logic        STALL;
  logic [3:0]  FLAGS;
  logic [63:0] REG_VAL;
  logic [1:0]  PS;
  logic [63:0] PC_IN;
  logic [31:0] IR;
  logic        IR_VALID;
  logic [4:0]  REG_ADDR;
  logic        HALTED;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .INSTR     (INSTR),
    .ROM_VALID (ROM_VALID),
    .STALL     (STALL),
    .FLAGS     (FLAGS),
    .REG_VAL   (REG_VAL),
    .PS        (PS),
    .PC_IN     (PC_IN),
    .IR        (IR),
    .IR_VALID  (IR_VALID),
    .REG_ADDR  (REG_ADDR),
    .HALTED    (HALTED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every IR_VALID pulse must match the oldest accept.
  always @(negedge clk) begin
    if (!reset && IR_VALID) begin
      if (sb.size() == 0) begin
        check_val("ir_spurious", 64'(IR_VALID), 64'd0);
      end else begin
        check_val("ir", 64'(IR), 64'(sb.pop_front()));
      end
    end
  end

  // Drive one cycle: inputs at posedge+2, PC controls checked at posedge+4,
  // then advance to the next posedge+2.
  task automatic step(input string tag, input logic [31:0] ins, input logic rv,
                      input logic st, input logic [3:0] fl, input logic [63:0] rval,
                      input logic [1:0] eps, input logic [63:0] epc, input bit acc);
    INSTR     = ins;
    ROM_VALID = rv;
    STALL     = st;
    FLAGS     = fl;
    REG_VAL   = rval;
    #2;
    check_val({tag, "_ps"}, 64'(PS), 64'(eps));
    check_val({tag, "_pc"}, PC_IN, epc);
    if (acc) sb.push_back(ins);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    INSTR     = C_ADD;
    ROM_VALID = 1'b1;
    STALL     = 1'b0;
    FLAGS     = 4'h0;
    REG_VAL   = 64'd0;
    #3;
    // Reset state, with a would-be accept presented.
    check_val("rst_ps", 64'(PS), 64'd0);
    check_val("rst_pc", PC_IN, 64'd0);
    check_val("rst_ir", 64'(IR), 64'd0);
    check_val("rst_irv", 64'(IR_VALID), 64'd0);
    check_val("rst_raddr", 64'(REG_ADDR), 64'd0);
    check_val("rst_halted", 64'(HALTED), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    step("add",     C_ADD,  1, 0, 4'h0, 0, 2'b01, 64'd0, 1);
    step("idle",    C_ADD,  0, 0, 4'h0, 0, 2'b00, 64'd0, 0);
    step("b_m3",    C_BM3,  1, 0, 4'h0, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    step("beq_t",   C_BEQ4, 1, 0, 4'b0100, 0, 2'b11, 64'd4, 1);
    step("beq_nt",  C_BEQ4, 1, 0, 4'b0000, 0, 2'b01, 64'd0, 1);
    // Stalled branch is held off, then evaluated with the later FLAGS.
    step("bne_stl", C_BNE4, 1, 1, 4'b0000, 0, 2'b00, 64'd0, 0);
    step("bne_nt",  C_BNE4, 1, 0, 4'b0100, 0, 2'b01, 64'd0, 1);
    step("bgt_t",   C_BGT,  1, 0, 4'b1001, 0, 2'b11, 64'd2, 1);
    step("bgt_nt",  C_BGT,  1, 0, 4'b1000, 0, 2'b01, 64'd0, 1);
    step("blt_m1",  C_BLTM, 1, 0, 4'b1000, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // CBZ taken; REGRD ignores ROM_VALID (no accept there).
    step("cbz",     C_CBZ,  1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    check_val("cbz_raddr", 64'(REG_ADDR), 64'd7);
    step("cbz_t",   C_ADD,  1, 0, 4'h0, 64'd0, 2'b11, 64'd2, 0);
    step("cbz2",    C_CBZ,  1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    step("cbz_nt",  C_ADD,  1, 1, 4'h0, 64'd5, 2'b01, 64'd0, 0);
    step("cbnz",    C_CBNZ, 1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    step("cbnz_t",  C_ADD,  0, 0, 4'h0, 64'd5, 2'b11, 64'd2, 0);

    // BR through X30.
    step("br",      C_BR30, 1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    check_val("br_raddr", 64'(REG_ADDR), 64'd30);
    step("br_ld",   C_ADD,  0, 0, 4'h0, 64'h40, 2'b10, 64'h40, 0);
    step("br_back", C_ADD,  1, 0, 4'h0, 0, 2'b01, 64'd0, 1);

    // Reset while in REGRD abandons the pending CBZ.
    step("cbz_rst", C_CBZ,  1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    reset = 1'b1;
    sb.delete();
    #1;
    check_val("rgrd_rst_ps", 64'(PS), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step("fresh",   C_ADD,  1, 0, 4'h0, 64'd0, 2'b01, 64'd0, 1);

    // Halt, then sit with ROM_VALID high.
    step("hlt",     C_HLT,  1, 0, 4'h0, 0, 2'b00, 64'd0, 1);
    for (int i = 0; i < 10; i++) begin
      check_val("hlt_flag", 64'(HALTED), 64'd1);
      if (i > 0) check_val("hlt_irv", 64'(IR_VALID), 64'd0);
      step("hlt_hold", C_BM3, 1, 0, 4'h0, 0, 2'b00, 64'd0, 0);
    end
    check_val("hlt_ir", 64'(IR), 64'(C_HLT));

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    check_val("async_halted", 64'(HALTED), 64'd0);
    check_val("async_ps", 64'(PS), 64'd0);
    check_val("async_ir", 64'(IR), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step("post_rst", C_ADD, 1, 0, 4'h0, 0, 2'b01, 64'd0, 1);
    step("drain",    C_ADD, 0, 0, 4'h0, 0, 2'b00, 64'd0, 0);
    @(posedge clk);
    #2;
    check_val("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
